// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin arbiter serialising core requests onto a single-port memory
module memory_arbiter #(
  parameter int DataWidth       = 8,
  parameter int NumOfRequesters = 4
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic [NumOfRequesters-1:0]           REQ,
  input  logic [NumOfRequesters-1:0]           REQ_WRITE,
  input  logic [NumOfRequesters*DataWidth-1:0] REQ_ADDR,
  input  logic [NumOfRequesters*DataWidth-1:0] REQ_DATA,
  output logic [NumOfRequesters-1:0]           GRANT,
  output logic [NumOfRequesters-1:0]           ACK,
  output logic [DataWidth-1:0]                 RD_DATA,
  output logic [DataWidth-1:0]                 MEM_ADDR,
  output logic [DataWidth-1:0]                 MEM_DATA_IN,
  output logic                                 MEM_WRITE,
  input  logic [DataWidth-1:0]                 MEM_DATA_OUT
);
  localparam int IdxW = $clog2(NumOfRequesters);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, next_state;
  logic [IdxW-1:0] owner, last, winner, cand;
  logic [NumOfRequesters-1:0] owner_oh;
  assign owner_oh = NumOfRequesters'(1) << owner;
  // state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else state <= next_state;
  end
  // next state: one transaction takes exactly IDLE -> ACCESS -> RESP
  always_comb next_state = state == IDLE ? (|REQ ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
  // scan from last+1 with wrap; descending loop so the nearest set request wins
  always_comb begin
    winner = last;
    cand = last;
    for (int k = NumOfRequesters; k >= 1; k--) begin
      cand = IdxW'((int'(last) + k) % NumOfRequesters);
      if (REQ[cand]) winner = cand;
    end
  end
  // owner and last-granted bookkeeping, read data capture at the end of ACCESS
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      owner   <= '0;
      last    <= IdxW'(NumOfRequesters - 1);
      RD_DATA <= '0;
    end else begin
      if (state == IDLE && |REQ) begin
        owner <= winner;
        last  <= winner;
      end
      if (state == ACCESS) RD_DATA <= MEM_DATA_OUT;
    end
  end
  // outputs decode from state so an async reset silences the memory port immediately
  always_comb begin
    GRANT       = state != IDLE ? owner_oh : '0;
    ACK         = state == RESP ? owner_oh : '0;
    MEM_ADDR    = state == ACCESS ? REQ_ADDR[owner*DataWidth +: DataWidth] : '0;
    MEM_DATA_IN = state == ACCESS ? REQ_DATA[owner*DataWidth +: DataWidth] : '0;
    MEM_WRITE   = state == ACCESS ? REQ_WRITE[owner] : 1'b0;
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed checks of arbitration order, latency and memory access
module tb_memory_arbiter;
  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  REQ, REQ_WRITE, GRANT, ACK;
  logic [31:0] REQ_ADDR, REQ_DATA;
  logic [7:0]  RD_DATA, MEM_ADDR, MEM_DATA_IN, MEM_DATA_OUT, rd;
  logic        MEM_WRITE;
  logic [7:0]  mem [256];
  int          tests = 0;
  int          fails = 0;

  memory_arbiter #(.DataWidth(8), .NumOfRequesters(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR),
    .REQ_DATA(REQ_DATA), .GRANT(GRANT), .ACK(ACK), .RD_DATA(RD_DATA), .MEM_ADDR(MEM_ADDR),
    .MEM_DATA_IN(MEM_DATA_IN), .MEM_WRITE(MEM_WRITE), .MEM_DATA_OUT(MEM_DATA_OUT)
  );

  always #5 CLK = ~CLK;

  // single-port memory: combinational read, write on posedge
  assign MEM_DATA_OUT = mem[MEM_ADDR];
  always @(posedge CLK) if (MEM_WRITE) mem[MEM_ADDR] <= MEM_DATA_IN;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    REQ = '0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // one isolated transaction from an IDLE start; returns RD_DATA seen with ACK
  task automatic xact(input int core, input logic wr, input logic [7:0] addr,
                      input logic [7:0] data, output logic [7:0] rdv);
    @(negedge CLK);
    REQ[core] = 1'b1;
    REQ_WRITE[core] = wr;
    REQ_ADDR[core*8 +: 8] = addr;
    REQ_DATA[core*8 +: 8] = data;
    @(negedge CLK);
    check("access_grant", GRANT, 32'(1 << core));
    check("access_ack", ACK, 0);
    check("access_we", MEM_WRITE, wr);
    check("access_addr", MEM_ADDR, addr);
    check("access_din", MEM_DATA_IN, data);
    @(negedge CLK);
    check("resp_ack", ACK, 32'(1 << core));
    check("resp_grant", GRANT, 32'(1 << core));
    check("resp_we", MEM_WRITE, 0);
    rdv = RD_DATA;
    REQ[core] = 1'b0;
    @(negedge CLK);
    check("idle_grant", GRANT, 0);
    check("idle_ack", ACK, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    RST = 1'b1;
    REQ = 4'($urandom);
    REQ_WRITE = 4'($urandom);
    REQ_ADDR = $urandom;
    REQ_DATA = $urandom;
    #1;
    check("rst_grant", GRANT, 0);
    check("rst_ack", ACK, 0);
    check("rst_rd", RD_DATA, 0);
    check("rst_we", MEM_WRITE, 0);
    check("rst_addr", MEM_ADDR, 0);
    repeat (2) @(negedge CLK);
    REQ = '0;
    REQ_WRITE = '0;
    RST = 1'b0;
    @(negedge CLK);
    check("idle_no_req", GRANT, 0);
    // write then read back from core 2
    xact(2, 1'b1, 8'h10, 8'h5A, rd);
    check("wr_rd_old", rd, 8'h00);
    xact(2, 1'b0, 8'h10, 8'h00, rd);
    check("rd_back", rd, 8'h5A);
    // all four requesting continuously from reset: 0,1,2,3,0
    do_reset();
    REQ_WRITE = '0;
    REQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("rr_grant", GRANT, 32'(1 << (i % 4)));
      @(negedge CLK);
      check("rr_ack", ACK, 32'(1 << (i % 4)));
      @(negedge CLK);
      check("rr_idle", GRANT, 0);
    end
    REQ = '0;
    // wrap from last=3 with cores 1 and 3 requesting: 1,3,1
    do_reset();
    REQ = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("wrap_grant", GRANT, (i == 1) ? 32'h8 : 32'h2);
      @(negedge CLK);
      check("wrap_ack", ACK, (i == 1) ? 32'h8 : 32'h2);
      @(negedge CLK);
    end
    REQ = '0;
    // read-before-write
    xact(1, 1'b1, 8'h20, 8'h11, rd);
    xact(0, 1'b1, 8'h20, 8'h22, rd);
    check("rbw_old", rd, 8'h11);
    xact(3, 1'b0, 8'h20, 8'h00, rd);
    check("rbw_new", rd, 8'h22);
    // reset during the ACCESS cycle of a write must suppress it
    @(negedge CLK);
    REQ[1] = 1'b1;
    REQ_WRITE[1] = 1'b1;
    REQ_ADDR[15:8] = 8'h30;
    REQ_DATA[15:8] = 8'hFF;
    @(negedge CLK);
    check("mid_we_before", MEM_WRITE, 1);
    RST = 1'b1;
    #1;
    check("mid_we_async", MEM_WRITE, 0);
    check("mid_grant_async", GRANT, 0);
    @(negedge CLK);
    check("mid_no_ack", ACK, 0);
    check("mid_no_grant", GRANT, 0);
    REQ = '0;
    RST = 1'b0;
    @(negedge CLK);
    check("mid_idle", GRANT, 0);
    xact(2, 1'b0, 8'h30, 8'h00, rd);
    check("mid_mem_kept", rd, 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
